id_ex_stage: RTL and testbench

- Operand-fetch and ID/EX pipeline register of the ARM64 pipeline.
- Sits directly downstream of the register file. It takes the regfile read data (rd1/rd2) together with decoded control.
- It forwards newer results from EX, MEM and WB, detects load-use hazards, and inserts bubbles.
- It registers the selected operands and control for the EX stage, and keeps a saturating stall counter.

---
 rtl/id_ex_stage.sv | 172 +++++++++++++++++
 tb/tb_id_ex_stage.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_stage.sv
// Operand fetch + ID/EX register: EX/MEM/WB forwarding, load-use bubble, saturating bubble counter.
// One cycle ID->EX; stall_id is combinational (hold or load-use), and a flush overrides both.
module id_ex_stage #(
    parameter int DATA_W = 64,
    parameter int CTRL_W = 16,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              id_valid,
    input  logic [4:0]        id_ra1,
    input  logic [4:0]        id_ra2,
    input  logic              id_use1,
    input  logic              id_use2,
    input  logic [4:0]        id_wa,
    input  logic              id_regwrite,
    input  logic              id_memread,
    input  logic [CTRL_W-1:0] id_ctrl,
    input  logic [DATA_W-1:0] id_imm,
    input  logic [63:0]       id_pc,
    input  logic [DATA_W-1:0] rd1,
    input  logic [DATA_W-1:0] rd2,
    input  logic [DATA_W-1:0] ex_result,
    input  logic              mem_regwrite,
    input  logic [4:0]        mem_wa,
    input  logic [DATA_W-1:0] mem_result,
    input  logic              wb_regwrite,
    input  logic [4:0]        wb_wa,
    input  logic [DATA_W-1:0] wb_result,
    input  logic              flush,
    input  logic              hold,
    output logic              stall_id,
    output logic              ex_valid,
    output logic [DATA_W-1:0] ex_a,
    output logic [DATA_W-1:0] ex_b,
    output logic [DATA_W-1:0] ex_imm,
    output logic [63:0]       ex_pc,
    output logic [4:0]        ex_wa,
    output logic              ex_regwrite,
    output logic              ex_memread,
    output logic [CTRL_W-1:0] ex_ctrl,
    output logic [CNT_W-1:0]  stall_count
);

    localparam logic [4:0] XZR = 5'd31;

    logic              valid_q, valid_d;
    logic              regwrite_q, regwrite_d;
    logic              memread_q, memread_d;
    logic [DATA_W-1:0] a_q, a_d, b_q, b_d, imm_q, imm_d;
    logic [63:0]       pc_q, pc_d;
    logic [4:0]        wa_q, wa_d;
    logic [CTRL_W-1:0] ctrl_q, ctrl_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic              ex_fwd_ok;
    logic [DATA_W-1:0] op_a, op_b;
    logic              lu;

    // A load in EX has no data yet; only ALU results may be forwarded from EX.
    assign ex_fwd_ok = valid_q & regwrite_q & ~memread_q;

    function automatic logic [DATA_W-1:0] fwd_sel(
        input logic [4:0]        ra,
        input logic [DATA_W-1:0] rd,
        input logic              ex_ok,
        input logic [4:0]        ex_dst,
        input logic [DATA_W-1:0] ex_val,
        input logic              mem_we,
        input logic [4:0]        mem_dst,
        input logic [DATA_W-1:0] mem_val,
        input logic              wb_we,
        input logic [4:0]        wb_dst,
        input logic [DATA_W-1:0] wb_val
    );
        logic [DATA_W-1:0] r;
        r = rd;
        if (ra != XZR) begin
            if (ex_ok && ex_dst == ra)          r = ex_val;
            else if (mem_we && mem_dst == ra)   r = mem_val;
            else if (wb_we && wb_dst == ra)     r = wb_val;
        end
        return r;
    endfunction

    always_comb begin
        op_a = fwd_sel(id_ra1, rd1, ex_fwd_ok, wa_q, ex_result, mem_regwrite, mem_wa,
                       mem_result, wb_regwrite, wb_wa, wb_result);
        op_b = fwd_sel(id_ra2, rd2, ex_fwd_ok, wa_q, ex_result, mem_regwrite, mem_wa,
                       mem_result, wb_regwrite, wb_wa, wb_result);
    end

    assign lu = id_valid & valid_q & memread_q & (wa_q != XZR) &
                ((id_use1 & (wa_q == id_ra1)) | (id_use2 & (wa_q == id_ra2)));

    assign stall_id = ~reset & ~flush & (hold | lu);

    always_comb begin
        valid_d    = valid_q;
        regwrite_d = regwrite_q;
        memread_d  = memread_q;
        a_d        = a_q;
        b_d        = b_q;
        imm_d      = imm_q;
        pc_d       = pc_q;
        wa_d       = wa_q;
        ctrl_d     = ctrl_q;
        cnt_d      = cnt_q;
        if (flush || !hold) begin
            a_d    = op_a;
            b_d    = op_b;
            imm_d  = id_imm;
            pc_d   = id_pc;
            wa_d   = id_wa;
            ctrl_d = id_ctrl;
        end
        if (flush) begin
            valid_d    = 1'b0;
            regwrite_d = 1'b0;
            memread_d  = 1'b0;
        end else if (hold) begin
            valid_d = valid_q;
        end else if (lu) begin
            valid_d    = 1'b0;
            regwrite_d = 1'b0;
            memread_d  = 1'b0;
            if (cnt_q != {CNT_W{1'b1}}) cnt_d = cnt_q + 1'b1;
        end else begin
            valid_d    = id_valid;
            regwrite_d = id_valid & id_regwrite;
            memread_d  = id_valid & id_memread;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q    <= 1'b0;
            regwrite_q <= 1'b0;
            memread_q  <= 1'b0;
            a_q        <= '0;
            b_q        <= '0;
            imm_q      <= '0;
            pc_q       <= '0;
            wa_q       <= '0;
            ctrl_q     <= '0;
            cnt_q      <= '0;
        end else begin
            valid_q    <= valid_d;
            regwrite_q <= regwrite_d;
            memread_q  <= memread_d;
            a_q        <= a_d;
            b_q        <= b_d;
            imm_q      <= imm_d;
            pc_q       <= pc_d;
            wa_q       <= wa_d;
            ctrl_q     <= ctrl_d;
            cnt_q      <= cnt_d;
        end
    end

    assign ex_valid    = valid_q;
    assign ex_regwrite = regwrite_q;
    assign ex_memread  = memread_q;
    assign ex_a        = a_q;
    assign ex_b        = b_q;
    assign ex_imm      = imm_q;
    assign ex_pc       = pc_q;
    assign ex_wa       = wa_q;
    assign ex_ctrl     = ctrl_q;
    assign stall_count = cnt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: directed vector table, then random traffic against a producer-list model.
module tb_id_ex_stage;

    localparam int CW = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset = 1'b0, id_valid = 1'b0, id_use1 = 1'b0, id_use2 = 1'b0;
    logic [4:0]  id_ra1 = '0, id_ra2 = '0, id_wa = '0, mem_wa = '0, wb_wa = '0;
    logic        id_regwrite = 1'b0, id_memread = 1'b0, mem_regwrite = 1'b0, wb_regwrite = 1'b0;
    logic [15:0] id_ctrl = '0;
    logic [63:0] id_imm = '0, id_pc = '0, rd1 = '0, rd2 = '0;
    logic [63:0] ex_result = '0, mem_result = '0, wb_result = '0;
    logic        flush = 1'b0, hold = 1'b0;
    logic        stall_id, ex_valid, ex_regwrite, ex_memread;
    logic [63:0] ex_a, ex_b, ex_imm, ex_pc;
    logic [4:0]  ex_wa;
    logic [15:0] ex_ctrl;
    logic [CW-1:0] stall_count;

    id_ex_stage #(.DATA_W(64), .CTRL_W(16), .CNT_W(CW)) dut (
        .clk(clk), .reset(reset), .id_valid(id_valid), .id_ra1(id_ra1), .id_ra2(id_ra2),
        .id_use1(id_use1), .id_use2(id_use2), .id_wa(id_wa), .id_regwrite(id_regwrite),
        .id_memread(id_memread), .id_ctrl(id_ctrl), .id_imm(id_imm), .id_pc(id_pc),
        .rd1(rd1), .rd2(rd2), .ex_result(ex_result), .mem_regwrite(mem_regwrite),
        .mem_wa(mem_wa), .mem_result(mem_result), .wb_regwrite(wb_regwrite), .wb_wa(wb_wa),
        .wb_result(wb_result), .flush(flush), .hold(hold), .stall_id(stall_id),
        .ex_valid(ex_valid), .ex_a(ex_a), .ex_b(ex_b), .ex_imm(ex_imm), .ex_pc(ex_pc),
        .ex_wa(ex_wa), .ex_regwrite(ex_regwrite), .ex_memread(ex_memread), .ex_ctrl(ex_ctrl),
        .stall_count(stall_count)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    typedef struct packed {
        logic        rst, flush, hold, valid, use1, use2, rw, mr;
        logic [4:0]  ra1, ra2, wa;
        logic [63:0] rd1, rd2, exr;
        logic        mrw;
        logic [4:0]  mwa;
        logic [63:0] mres;
        logic        wrw;
        logic [4:0]  wwa;
        logic [63:0] wres;
        logic        chk_a;
        logic        e_stall, e_valid;
        logic [63:0] e_a, e_b;
        logic [CW-1:0] e_cnt;
    } vec_t;

    localparam int NV = 19;
    vec_t t [NV];

    typedef struct {
        logic        v, rw, mr;
        logic [4:0]  wa;
        logic [63:0] a, b, imm, pc;
        logic [15:0] ctrl;
    } ex_m_t;

    ex_m_t       m, nm;
    logic [CW-1:0] mcnt, ncnt;

    // Youngest in-flight producer of register r wins; X31 is never produced.
    function automatic logic [63:0] newest(input logic [4:0] r, input logic [63:0] rd);
        logic        we [3];
        logic [4:0]  dst [3];
        logic [63:0] val [3];
        we[0] = m.v && m.rw && !m.mr; dst[0] = m.wa;  val[0] = ex_result;
        we[1] = mem_regwrite;         dst[1] = mem_wa; val[1] = mem_result;
        we[2] = wb_regwrite;          dst[2] = wb_wa;  val[2] = wb_result;
        if (r == 5'd31) return rd;
        for (int k = 0; k < 3; k++)
            if (we[k] && dst[k] == r) return val[k];
        return rd;
    endfunction

    function automatic logic [4:0] pick_reg();
        return ($urandom_range(0, 7) == 0) ? 5'd31 : 5'($urandom_range(0, 3));
    endfunction

    initial begin
        t[0]  = '{rst:1'b1, default:'0};
        t[1]  = '{valid:1'b1, wa:5'd1, rw:1'b1, ra1:5'd5, use1:1'b1, rd1:64'd100,
                  chk_a:1'b1, e_valid:1'b1, e_a:64'd100, default:'0};
        t[2]  = '{valid:1'b1, ra1:5'd1, use1:1'b1, rd1:64'd1, exr:64'd5, wa:5'd2, rw:1'b1,
                  chk_a:1'b1, e_valid:1'b1, e_a:64'd5, default:'0};
        t[3]  = '{valid:1'b1, ra1:5'd3, use1:1'b1, rd1:64'd3, wrw:1'b1, wwa:5'd3, wres:64'hAB,
                  wa:5'd2, chk_a:1'b1, e_valid:1'b1, e_a:64'hAB, default:'0};
        t[4]  = '{valid:1'b1, ra1:5'd9, rd1:64'd9, wa:5'd2, rw:1'b1,
                  chk_a:1'b1, e_valid:1'b1, e_a:64'd9, default:'0};
        t[5]  = '{valid:1'b1, ra1:5'd2, use1:1'b1, exr:64'd10, mrw:1'b1, mwa:5'd2, mres:64'd20,
                  wrw:1'b1, wwa:5'd2, wres:64'd30, wa:5'd2, chk_a:1'b1, e_valid:1'b1,
                  e_a:64'd10, default:'0};
        t[6]  = '{valid:1'b1, ra1:5'd2, use1:1'b1, exr:64'd10, mrw:1'b1, mwa:5'd2, mres:64'd20,
                  wrw:1'b1, wwa:5'd2, wres:64'd30, chk_a:1'b1, e_valid:1'b1, e_a:64'd20,
                  default:'0};
        t[7]  = '{valid:1'b1, ra1:5'd2, use1:1'b1, exr:64'd10, wrw:1'b1, wwa:5'd2, wres:64'd30,
                  wa:5'd4, rw:1'b1, mr:1'b1, chk_a:1'b1, e_valid:1'b1, e_a:64'd30, default:'0};
        t[8]  = '{valid:1'b1, ra1:5'd4, use1:1'b1, rd1:64'd4, wa:5'd5, rw:1'b1,
                  e_stall:1'b1, e_cnt:4'd1, default:'0};
        t[9]  = '{valid:1'b1, ra1:5'd4, use1:1'b1, rd1:64'd4, wa:5'd5, rw:1'b1, mrw:1'b1,
                  mwa:5'd4, mres:64'h77, chk_a:1'b1, e_valid:1'b1, e_a:64'h77, e_cnt:4'd1,
                  default:'0};
        t[10] = '{valid:1'b1, wa:5'd4, rw:1'b1, mr:1'b1, chk_a:1'b1, e_valid:1'b1,
                  e_cnt:4'd1, default:'0};
        t[11] = '{valid:1'b1, use1:1'b1, ra2:5'd4, rd2:64'h55, wa:5'd31, rw:1'b1, mr:1'b1,
                  chk_a:1'b1, e_valid:1'b1, e_b:64'h55, e_cnt:4'd1, default:'0};
        t[12] = '{valid:1'b1, ra1:5'd31, use1:1'b1, exr:64'h99, mrw:1'b1, mwa:5'd31,
                  mres:64'h88, wrw:1'b1, wwa:5'd31, wres:64'h66, wa:5'd7, rw:1'b1, mr:1'b1,
                  chk_a:1'b1, e_valid:1'b1, e_cnt:4'd1, default:'0};
        t[13] = '{valid:1'b1, ra1:5'd7, use1:1'b1, rd1:64'd7, flush:1'b1, hold:1'b1,
                  e_cnt:4'd1, default:'0};
        t[14] = '{valid:1'b1, ra1:5'd1, rd1:64'h44, wa:5'd8, rw:1'b1, mr:1'b1,
                  chk_a:1'b1, e_valid:1'b1, e_a:64'h44, e_cnt:4'd1, default:'0};
        t[15] = '{valid:1'b1, ra1:5'd8, use1:1'b1, rd1:64'd8, hold:1'b1, chk_a:1'b1,
                  e_stall:1'b1, e_valid:1'b1, e_a:64'h44, e_cnt:4'd1, default:'0};
        t[16] = '{valid:1'b1, ra1:5'd8, use1:1'b1, rd1:64'd8, e_stall:1'b1, e_cnt:4'd2,
                  default:'0};
        t[17] = '{valid:1'b1, wa:5'd8, rw:1'b1, mr:1'b1, chk_a:1'b1, e_valid:1'b1,
                  e_cnt:4'd2, default:'0};
        t[18] = '{rst:1'b1, valid:1'b1, ra1:5'd8, use1:1'b1, rd1:64'h123, default:'0};

        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            reset = t[i].rst; flush = t[i].flush; hold = t[i].hold;
            id_valid = t[i].valid; id_use1 = t[i].use1; id_use2 = t[i].use2;
            id_regwrite = t[i].rw; id_memread = t[i].mr;
            id_ra1 = t[i].ra1; id_ra2 = t[i].ra2; id_wa = t[i].wa;
            rd1 = t[i].rd1; rd2 = t[i].rd2; ex_result = t[i].exr;
            mem_regwrite = t[i].mrw; mem_wa = t[i].mwa; mem_result = t[i].mres;
            wb_regwrite = t[i].wrw; wb_wa = t[i].wwa; wb_result = t[i].wres;
            id_imm = 64'h1000 + 64'(i); id_pc = 64'h4000 + 64'(4 * i); id_ctrl = 16'(i + 1);
            #1;
            chk($sformatf("v%0d stall_id", i), 64'(stall_id), 64'(t[i].e_stall));
            @(posedge clk); #1;
            chk($sformatf("v%0d ex_valid", i), 64'(ex_valid), 64'(t[i].e_valid));
            chk($sformatf("v%0d stall_count", i), 64'(stall_count), 64'(t[i].e_cnt));
            if (!t[i].e_valid) begin
                chk($sformatf("v%0d ex_regwrite", i), 64'(ex_regwrite), 64'd0);
                chk($sformatf("v%0d ex_memread", i), 64'(ex_memread), 64'd0);
            end
            if (t[i].chk_a) begin
                chk($sformatf("v%0d ex_a", i), ex_a, t[i].e_a);
                chk($sformatf("v%0d ex_b", i), ex_b, t[i].e_b);
                if (!t[i].hold) begin
                    chk($sformatf("v%0d ex_pc", i), ex_pc, 64'h4000 + 64'(4 * i));
                    chk($sformatf("v%0d ex_wa", i), 64'(ex_wa), 64'(t[i].wa));
                    chk($sformatf("v%0d ex_regwrite", i), 64'(ex_regwrite), 64'(t[i].rw));
                end
            end
            if (t[i].rst) begin
                chk($sformatf("v%0d rst ex_a", i), ex_a, 64'd0);
                chk($sformatf("v%0d rst ex_b", i), ex_b, 64'd0);
                chk($sformatf("v%0d rst ex_imm", i), ex_imm, 64'd0);
                chk($sformatf("v%0d rst ex_pc", i), ex_pc, 64'd0);
                chk($sformatf("v%0d rst ex_wa", i), 64'(ex_wa), 64'd0);
                chk($sformatf("v%0d rst ex_ctrl", i), 64'(ex_ctrl), 64'd0);
                chk($sformatf("v%0d rst ex_rw_mr", i), {62'd0, ex_regwrite, ex_memread}, 64'd0);
            end
        end

        // Table ended with reset, so the model starts from the cleared state.
        m = '{default:'0};
        mcnt = '0;
        for (int c = 0; c < 800; c++) begin
            logic lu_m, stall_m;
            @(negedge clk);
            reset = ($urandom_range(0, 199) == 0);
            flush = ($urandom_range(0, 9) == 0);
            hold = ($urandom_range(0, 7) == 0);
            id_valid = ($urandom_range(0, 6) != 0);
            id_use1 = $urandom_range(0, 1); id_use2 = $urandom_range(0, 1);
            id_ra1 = pick_reg(); id_ra2 = pick_reg(); id_wa = pick_reg();
            id_regwrite = $urandom_range(0, 3) != 0; id_memread = $urandom_range(0, 2) == 0;
            id_ctrl = 16'($urandom); id_imm = {$urandom, $urandom}; id_pc = {$urandom, $urandom};
            rd1 = {$urandom, $urandom}; rd2 = {$urandom, $urandom};
            ex_result = {$urandom, $urandom}; mem_result = {$urandom, $urandom};
            wb_result = {$urandom, $urandom};
            mem_regwrite = $urandom_range(0, 1); mem_wa = pick_reg();
            wb_regwrite = $urandom_range(0, 1); wb_wa = pick_reg();
            #1;
            lu_m = id_valid && m.v && m.mr && m.wa != 5'd31 &&
                   ((id_use1 && id_ra1 == m.wa) || (id_use2 && id_ra2 == m.wa));
            stall_m = !reset && !flush && (hold || lu_m);
            chk("rnd stall_id", 64'(stall_id), 64'(stall_m));
            nm = m;
            ncnt = mcnt;
            if (reset) begin
                nm = '{default:'0};
                ncnt = '0;
            end else if (flush) begin
                nm.v = 1'b0; nm.rw = 1'b0; nm.mr = 1'b0;
            end else if (hold) begin
                nm = m;
            end else if (lu_m) begin
                nm.v = 1'b0; nm.rw = 1'b0; nm.mr = 1'b0;
                ncnt = (mcnt == {CW{1'b1}}) ? mcnt : mcnt + 1'b1;
            end else begin
                nm.v = id_valid; nm.rw = id_valid && id_regwrite; nm.mr = id_valid && id_memread;
                nm.a = newest(id_ra1, rd1); nm.b = newest(id_ra2, rd2);
                nm.imm = id_imm; nm.pc = id_pc; nm.wa = id_wa; nm.ctrl = id_ctrl;
            end
            @(posedge clk); #1;
            m = nm;
            mcnt = ncnt;
            chk("rnd ex_valid", 64'(ex_valid), 64'(m.v));
            chk("rnd ex_regwrite", 64'(ex_regwrite), 64'(m.rw));
            chk("rnd ex_memread", 64'(ex_memread), 64'(m.mr));
            chk("rnd stall_count", 64'(stall_count), 64'(mcnt));
            if (m.v) begin
                chk("rnd ex_a", ex_a, m.a);
                chk("rnd ex_b", ex_b, m.b);
                chk("rnd ex_imm", ex_imm, m.imm);
                chk("rnd ex_pc", ex_pc, m.pc);
                chk("rnd ex_wa", 64'(ex_wa), 64'(m.wa));
                chk("rnd ex_ctrl", 64'(ex_ctrl), 64'(m.ctrl));
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
